// File: rtl/game_state_ctrl_pkg.sv
// Shared state and winner encodings for the match controller and the ball object.
// Pure definitions, no logic.
package game_state_ctrl_pkg;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'b00,
        GS_PLAY  = 2'b01,
        GS_PAUSE = 2'b10,
        GS_OVER  = 2'b11
    } gs_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/game_state_ctrl_btn_debounce.sv
// Button synchroniser + tick-paced debouncer; level settles DEBOUNCE_MS ticks after input is stable.
// Latency: 2 clk sync plus DEBOUNCE_MS ticks; rise_pulse is 1 clk wide; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_MS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            cnt        <= '0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            rise_pulse <= 1'b0;
            if (tick) begin
                // A sample equal to the accepted level means the candidate edge was a bounce.
                if (sync2 == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    level      <= sync2;
                    rise_pulse <= sync2;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Match-level controller: start/point/win sequencing, winner report and held match reset.
// Latency: one clk from condition to state change; all outputs registered; no backpressure.
module game_state_ctrl
    import game_state_ctrl_pkg::*;
#(
    parameter int WIN_SCORE      = 7,
    parameter int PAUSE_MS       = 1000,
    parameter int DEBOUNCE_MS    = 10,
    parameter int RST_HOLD_TICKS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1ms,
    input  logic       btn_start,
    input  logic [3:0] p1_score,
    input  logic [3:0] p2_score,
    output logic [1:0] game_state,
    output logic [1:0] winner,
    output logic       match_rst_n,
    output logic       point_pulse
);

    localparam int PW = $clog2(PAUSE_MS + 1);
    localparam int HW = $clog2(RST_HOLD_TICKS + 1);
    localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_MS - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD_TICKS - 1);
    localparam logic [3:0]    WIN_THR    = 4'(WIN_SCORE);

    gs_t           state_q;
    gs_t           state_d;
    logic [1:0]    winner_d;
    logic          rst_req;
    logic          start_evt;
    logic          btn_level;
    logic          score_chg;
    logic          pause_done;
    logic [3:0]    p1_shadow;
    logic [3:0]    p2_shadow;
    logic [PW-1:0] pause_cnt;
    logic [HW-1:0] hold_cnt;

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_start_btn (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick_1ms),
        .raw        (btn_start),
        .level      (btn_level),
        .rise_pulse (start_evt)
    );

    assign score_chg  = (p1_score != p1_shadow) || (p2_score != p2_shadow);
    assign pause_done = tick_1ms && (pause_cnt == PAUSE_LAST);
    assign game_state = state_q;

    always_comb begin
        state_d  = state_q;
        winner_d = winner;
        rst_req  = 1'b0;
        case (state_q)
            GS_IDLE: begin
                if (start_evt && match_rst_n) state_d = GS_PLAY;
            end
            GS_PLAY: begin
                // Player 1 is checked first so a simultaneous finish goes to player 1.
                if (score_chg) begin
                    if (p1_score >= WIN_THR) begin
                        state_d  = GS_OVER;
                        winner_d = WIN_P1;
                    end else if (p2_score >= WIN_THR) begin
                        state_d  = GS_OVER;
                        winner_d = WIN_P2;
                    end else begin
                        state_d = GS_PAUSE;
                    end
                end
            end
            GS_PAUSE: begin
                if (pause_done) state_d = GS_PLAY;
            end
            GS_OVER: begin
                if (start_evt) begin
                    state_d  = GS_IDLE;
                    winner_d = WIN_NONE;
                    rst_req  = 1'b1;
                end
            end
            default: state_d = GS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= GS_IDLE;
            winner      <= WIN_NONE;
            point_pulse <= 1'b0;
            p1_shadow   <= '0;
            p2_shadow   <= '0;
        end else begin
            state_q     <= state_d;
            winner      <= winner_d;
            point_pulse <= score_chg;
            p1_shadow   <= p1_score;
            p2_shadow   <= p2_score;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pause_cnt <= '0;
        end else if (state_q != GS_PAUSE) begin
            pause_cnt <= '0;
        end else if (tick_1ms && (pause_cnt != PAUSE_LAST)) begin
            pause_cnt <= pause_cnt + PW'(1);
        end
    end

    // Hold is measured in ticks so a slowly clocked ball object still sees the reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_rst_n <= 1'b0;
            hold_cnt    <= '0;
        end else if (rst_req) begin
            match_rst_n <= 1'b0;
            hold_cnt    <= '0;
        end else if (!match_rst_n && tick_1ms) begin
            if (hold_cnt == HOLD_LAST) begin
                match_rst_n <= 1'b1;
                hold_cnt    <= '0;
            end else begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

endmodule
